result_sel_reg: RTL and testbench
=================================

RESULT_SEL_REG -- requirements
Module: result_sel_reg

Interface
REQ-001 Parameter WIDTH, default 32, bit width of each source result and of out_data.
REQ-002 Parameter NUM_SRC, default 8, number of result sources (2..16).
REQ-003 Parameter SEL_W, default 4, width of the select code; SEL_W SHALL be at least clog2(NUM_SRC).
REQ-004 Parameter TIMEOUT, default 15, maximum WAIT cycles before abort (1..255).
REQ-005 clk  input  1  single clock, all state updates on the rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 in_data  input  NUM_SRC*WIDTH  flattened sources; source k occupies bits [k*WIDTH +: WIDTH].
REQ-008 src_valid  input  NUM_SRC  bit k high means source k holds a valid result this cycle.
REQ-009 sel  input  SEL_W  select code, sampled only on request acceptance.
REQ-010 req_valid  input  1  a select request is presented.
REQ-011 req_ready  output  1  block can accept a request this cycle.
REQ-012 out_data  output  WIDTH  registered selected result.
REQ-013 out_valid  output  1  out_data is valid.
REQ-014 out_ready  input  1  consumer accepts out_data.
REQ-015 err_sel  output  1  out-of-range select code; meaningful only while out_valid is high.
REQ-016 err_timeout  output  1  source wait expired; meaningful only while out_valid is high.

Function
REQ-017 The FSM SHALL have the states IDLE, WAIT and HOLD.
REQ-018 req_ready SHALL be high in IDLE, and in HOLD when out_ready is high; it SHALL be low otherwise.
REQ-019 Acceptance: req_valid and req_ready high at an edge -> sel latched into sel_q, wait counter cleared, next state WAIT.
REQ-020 Code mapping: sel < NUM_SRC -> source sel; sel >= NUM_SRC -> source 0 with err_sel set for that transaction.
REQ-021 WAIT: when src_valid[sel_q] is high at an edge, the selected data SHALL be registered into out_data, out_valid set, and the FSM SHALL go to HOLD.
REQ-022 Minimum latency: out_valid SHALL rise one edge after acceptance.
REQ-023 WAIT: when src_valid[sel_q] is low, the counter increments each cycle.
REQ-024 When the counter reaches TIMEOUT with src_valid[sel_q] still low, the block SHALL set out_data to 0, err_timeout to 1 and out_valid to 1, then go to HOLD.
REQ-025 HOLD: out_data, out_valid and the error flags SHALL stay stable until out_ready is high at an edge.
REQ-026 HOLD with out_ready and req_valid both high SHALL complete the transfer and accept the new request in the same edge, going to WAIT with out_valid low (back-to-back).
REQ-027 HOLD with out_ready high and req_valid low SHALL clear out_valid and go to IDLE.
REQ-028 Changes on sel or in_data of unselected sources SHALL NOT affect an in-flight transaction.
REQ-029 err_sel and err_timeout SHALL be cleared on every acceptance.

Reset
REQ-030 rst high at an edge SHALL force state IDLE, out_data 0, out_valid 0, err_sel 0, err_timeout 0, counter 0 and sel_q 0; this overrides any other event in that cycle.
REQ-031 Reset asserted mid-transaction SHALL abort the transaction with no output produced.

Structure
REQ-032 Package result_sel_pkg SHALL hold the state encoding (IDLE=0, WAIT=1, HOLD=2) and the default parameter constants.
REQ-033 The timeout counter SHALL be a sub-module wait_timer (clear, enable, expired) with an 8-bit count.

Verification
REQ-034 The bench SHALL cover: WIDTH=32, NUM_SRC=8, src 3 = 0xDEADBEEF with src_valid[3]=1 and sel=3 accepted -> out_valid one edge later, out_data=0xDEADBEEF, flags 0.
REQ-035 The bench SHALL cover: sel=9 with src 0 = 0x11 valid -> out_data=0x11, err_sel=1.
REQ-036 The bench SHALL cover: sel=5 with src_valid[5] low for 20 cycles and TIMEOUT=15 -> out_data=0, err_timeout=1 after 15 WAIT cycles.
REQ-037 The bench SHALL cover: src_valid[2] raised after 4 WAIT cycles -> out_valid on the next edge; with out_ready held low for 3 cycles, out_data stays stable.
REQ-038 The bench SHALL cover: HOLD with out_ready=1 and req_valid=1 (sel=1) -> transfer and acceptance in the same edge, out_valid low for exactly one cycle.
REQ-039 The bench SHALL cover: rst asserted during WAIT -> all outputs 0 next cycle and req_ready=1.

Source files
------------

// File: rtl/result_sel_pkg.sv
// -----------------------------------------------------------------------------
// result_sel_pkg
// Shared definitions for the result select register: FSM state encoding,
// default parameter values and the width of the source-wait counter.
// No ports (package).
// -----------------------------------------------------------------------------
package result_sel_pkg;

   localparam int unsigned DEF_WIDTH   = 32;
   localparam int unsigned DEF_NUM_SRC = 8;
   localparam int unsigned DEF_SEL_W   = 4;
   localparam int unsigned DEF_TIMEOUT = 15;

   // Width of the source-wait counter; holds any TIMEOUT in 1..255.
   localparam int unsigned TIMER_W = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      HOLD = 2'd2
   } state_t;

endpackage : result_sel_pkg

// File: rtl/wait_timer.sv
// -----------------------------------------------------------------------------
// wait_timer
// Counts cycles spent waiting for the selected source to become valid.
//   clk     : clock, rising edge
//   clear   : synchronous clear of the count (reset or new request)
//   enable  : advance the count by one this cycle
//   expired : the count advances to LIMIT on this cycle if enable is high,
//             i.e. this is the last wait cycle the owner may spend
// -----------------------------------------------------------------------------
module wait_timer
   import result_sel_pkg::*;
#(
   parameter int unsigned LIMIT = DEF_TIMEOUT
) (
   input  logic clk,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   logic [TIMER_W-1:0] count;

   always_ff @(posedge clk) begin
      if (clear) begin
         count <= '0;
      end else if (enable) begin
         count <= count + TIMER_W'(1);
      end
   end

   // Look one step ahead so the abort lands on the same edge at which the
   // count would reach LIMIT, giving exactly LIMIT wait cycles.
   assign expired = (count == TIMER_W'(LIMIT - 1));

endmodule : wait_timer

// File: rtl/result_sel_reg.sv
// -----------------------------------------------------------------------------
// result_sel_reg
// Accepts a select request, waits for the chosen source to present a valid
// result (or aborts after TIMEOUT cycles), registers it and holds it until the
// consumer takes it. A new request may be accepted on the same edge the held
// result is consumed.
//   clk         : clock, rising edge
//   rst         : synchronous active-high reset
//   in_data     : NUM_SRC flattened results, source k at [k*WIDTH +: WIDTH]
//   src_valid   : per-source result valid
//   sel         : select code, sampled on acceptance only
//   req_valid   : request present
//   req_ready   : request can be accepted this cycle
//   out_data    : registered selected result (0 on timeout)
//   out_valid   : out_data valid
//   out_ready   : consumer accepts out_data
//   err_sel     : select code was out of range (source 0 was used)
//   err_timeout : selected source never became valid within TIMEOUT cycles
// SEL_W must be at least clog2(NUM_SRC).
// -----------------------------------------------------------------------------
module result_sel_reg
   import result_sel_pkg::*;
#(
   parameter int unsigned WIDTH   = DEF_WIDTH,
   parameter int unsigned NUM_SRC = DEF_NUM_SRC,
   parameter int unsigned SEL_W   = DEF_SEL_W,
   parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_SRC*WIDTH-1:0]   in_data,
   input  logic [NUM_SRC-1:0]         src_valid,
   input  logic [SEL_W-1:0]           sel,
   input  logic                       req_valid,
   output logic                       req_ready,
   output logic [WIDTH-1:0]           out_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic                       err_sel,
   output logic                       err_timeout
);

   state_t             state;
   logic [SEL_W-1:0]   sel_q;
   logic               accept;
   logic               sel_bad;
   logic               src_hit;
   logic [WIDTH-1:0]   src_word;
   logic               timer_clear;
   logic               timer_en;
   logic               timer_expired;

   assign req_ready = (state == IDLE) || ((state == HOLD) && out_ready);
   assign accept    = req_valid && req_ready;

   // Out-of-range codes fall back to source 0; the flag is reported with
   // the result of that transaction.
   assign sel_bad = (32'(sel_q) >= NUM_SRC);

   // Source mux driven only by the latched code, so later changes on sel or
   // on other sources cannot disturb an in-flight transaction.
   // NOTE: every signal assigned in always_comb gets a default first; a path
   // that leaves one unassigned would infer a latch.
   always_comb begin
      src_hit  = 1'b0;
      src_word = '0;
      for (int unsigned k = 0; k < NUM_SRC; k++) begin
         if ((sel_bad && (k == 0)) || (!sel_bad && (32'(sel_q) == k))) begin
            src_hit  = src_valid[k];
            src_word = in_data[k*WIDTH +: WIDTH];
         end
      end
   end

   assign timer_clear = rst || accept;
   assign timer_en    = (state == WAIT) && !src_hit;

   wait_timer #(
      .LIMIT (TIMEOUT)
   ) u_wait_timer (
      .clk     (clk),
      .clear   (timer_clear),
      .enable  (timer_en),
      .expired (timer_expired)
   );

   // NOTE: all state here is updated with non-blocking assignments so every
   // register samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         sel_q       <= '0;
         out_data    <= '0;
         out_valid   <= 1'b0;
         err_sel     <= 1'b0;
         err_timeout <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  sel_q       <= sel;
                  err_sel     <= 1'b0;
                  err_timeout <= 1'b0;
                  state       <= WAIT;
               end
            end

            WAIT: begin
               if (src_hit) begin
                  out_data  <= src_word;
                  out_valid <= 1'b1;
                  err_sel   <= sel_bad;
                  state     <= HOLD;
               end else if (timer_expired) begin
                  out_data    <= '0;
                  out_valid   <= 1'b1;
                  err_sel     <= sel_bad;
                  err_timeout <= 1'b1;
                  state       <= HOLD;
               end
            end

            HOLD: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  if (accept) begin
                     // Back-to-back: hand off the held result and start the
                     // next transaction on the same edge.
                     sel_q       <= sel;
                     err_sel     <= 1'b0;
                     err_timeout <= 1'b0;
                     state       <= WAIT;
                  end else begin
                     state <= IDLE;
                  end
               end
            end

            default: begin
               state     <= IDLE;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule : result_sel_reg

// File: tb/tb_result_sel_reg.sv
// -----------------------------------------------------------------------------
// tb_result_sel_reg
// Self-checking bench for result_sel_reg (WIDTH=32, NUM_SRC=8, SEL_W=4,
// TIMEOUT=15). Expected results come from a transaction-level model: a request
// for source s whose data turns valid after L low wait cycles completes after
// min(L+1, TIMEOUT) edges, with the data or zero plus the error flags.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_result_sel_reg;

   localparam int W  = 32;
   localparam int N  = 8;
   localparam int SW = 4;
   localparam int TO = 15;

   logic            clk = 1'b0;
   logic            rst;
   logic [N*W-1:0]  in_data;
   logic [N-1:0]    src_valid;
   logic [SW-1:0]   sel;
   logic            req_valid;
   logic            req_ready;
   logic [W-1:0]    out_data;
   logic            out_valid;
   logic            out_ready;
   logic            err_sel;
   logic            err_timeout;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   result_sel_reg #(
      .WIDTH   (W),
      .NUM_SRC (N),
      .SEL_W   (SW),
      .TIMEOUT (TO)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .in_data     (in_data),
      .src_valid   (src_valid),
      .sel         (sel),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .out_data    (out_data),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .err_sel     (err_sel),
      .err_timeout (err_timeout)
   );

   // ---------------------------------------------------------------- model
   function automatic int eff_src(input int s);
      return (s < N) ? s : 0;
   endfunction

   // Expected completion of one transaction from the request's point of view.
   task automatic model_txn(input int s, input logic [W-1:0] value, input int low_edges,
                            output int lat, output logic [W-1:0] d,
                            output logic es, output logic et);
      es = (s >= N);
      if (low_edges < TO) begin
         lat = low_edges + 1;
         d   = value;
         et  = 1'b0;
      end else begin
         lat = TO;
         d   = '0;
         et  = 1'b1;
      end
   endtask

   // ---------------------------------------------------------------- drivers
   task automatic randomize_others(input int keep);
      for (int k = 0; k < N; k++) begin
         if (k != keep) begin
            in_data[k*W +: W] = $urandom;
            src_valid[k]      = 1'($urandom_range(0, 1));
         end
      end
   endtask

   // Issue one request from IDLE and wait (bounded) for out_valid. The chosen
   // source is low for low_edges wait edges, then valid. Returns lat=-1 if no
   // result appears. Leaves the DUT in HOLD with out_ready low.
   task automatic run_txn(input int s, input logic [W-1:0] value, input int low_edges,
                          output int lat, output logic [W-1:0] d,
                          output logic es, output logic et);
      int e;
      e = eff_src(s);
      @(negedge clk);
      req_valid         = 1'b1;
      sel               = SW'(s);
      in_data[e*W +: W] = value;
      src_valid[e]      = 1'($urandom_range(0, 1));
      randomize_others(e);
      @(posedge clk);
      lat = -1;
      d   = '0;
      es  = 1'b0;
      et  = 1'b0;
      for (int k = 1; k <= TO + 5; k++) begin
         @(negedge clk);
         req_valid    = 1'b0;
         sel          = SW'($urandom);
         randomize_others(e);
         src_valid[e] = (k > low_edges);
         @(posedge clk);
         #1;
         if (out_valid) begin
            lat = k;
            d   = out_data;
            es  = err_sel;
            et  = err_timeout;
            break;
         end
      end
   endtask

   task automatic release_out();
      @(negedge clk);
      req_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
   endtask

   // ---------------------------------------------------------------- tests
   task automatic test_reset();
      rst       = 1'b1;
      req_valid = 1'b1;
      sel       = 4'd3;
      out_ready = 1'b0;
      in_data   = '1;
      src_valid = '1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({out_valid, err_sel, err_timeout, out_data, req_ready} !== {1'b0, 1'b0, 1'b0, 32'h0, 1'b1}) begin
         failures++;
         $display("FAIL reset_state got v=%b es=%b et=%b d=%h rdy=%b exp v=0 es=0 et=0 d=0 rdy=1",
                  out_valid, err_sel, err_timeout, out_data, req_ready);
      end
      @(negedge clk);
      rst       = 1'b0;
      req_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b0) begin
         failures++;
         $display("FAIL reset_no_accept got out_valid=%b exp 0", out_valid);
      end
   endtask

   task automatic test_basic();
      int lat;
      logic [W-1:0] d;
      logic es, et;
      run_txn(3, 32'hDEADBEEF, 0, lat, d, es, et);
      checks++;
      if (lat !== 1) begin
         failures++;
         $display("FAIL basic_latency got=%0d exp=1", lat);
      end
      checks++;
      if ({d, es, et} !== {32'hDEADBEEF, 1'b0, 1'b0}) begin
         failures++;
         $display("FAIL basic_result got d=%h es=%b et=%b exp d=deadbeef es=0 et=0", d, es, et);
      end
      release_out();
      checks++;
      if ({out_valid, req_ready} !== 2'b01) begin
         failures++;
         $display("FAIL basic_release got v=%b rdy=%b exp v=0 rdy=1", out_valid, req_ready);
      end
   endtask

   task automatic test_bad_sel();
      int lat;
      logic [W-1:0] d;
      logic es, et;
      run_txn(9, 32'h11, 0, lat, d, es, et);
      checks++;
      if ({lat, d, es, et} !== {32'd1, 32'h11, 1'b1, 1'b0}) begin
         failures++;
         $display("FAIL bad_sel got lat=%0d d=%h es=%b et=%b exp lat=1 d=11 es=1 et=0", lat, d, es, et);
      end
      release_out();
   endtask

   task automatic test_timeout();
      int lat, elat;
      logic [W-1:0] d, ed, v;
      logic es, et, ees, eet;
      int sels[3] = '{5, 5, 12};
      int lows[3] = '{20, TO - 1, 20};
      for (int i = 0; i < 3; i++) begin
         v = $urandom;
         model_txn(sels[i], v, lows[i], elat, ed, ees, eet);
         run_txn(sels[i], v, lows[i], lat, d, es, et);
         checks++;
         if ({lat, d, es, et} !== {elat, ed, ees, eet}) begin
            failures++;
            $display("FAIL timeout_%0d got lat=%0d d=%h es=%b et=%b exp lat=%0d d=%h es=%b et=%b",
                     i, lat, d, es, et, elat, ed, ees, eet);
         end
         release_out();
      end
   endtask

   task automatic test_hold_stable();
      int lat;
      logic [W-1:0] d;
      logic es, et;
      run_txn(2, 32'hCAFE0002, 4, lat, d, es, et);
      checks++;
      if ({lat, d} !== {32'd5, 32'hCAFE0002}) begin
         failures++;
         $display("FAIL hold_first got lat=%0d d=%h exp lat=5 d=cafe0002", lat, d);
      end
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         req_valid = 1'($urandom_range(0, 1));
         sel       = SW'($urandom);
         randomize_others(-1);
         @(posedge clk);
         #1;
         checks++;
         if ({out_valid, out_data, err_sel, err_timeout, req_ready} !== {1'b1, 32'hCAFE0002, 1'b0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL hold_stable_%0d got v=%b d=%h es=%b et=%b rdy=%b exp v=1 d=cafe0002 es=0 et=0 rdy=0",
                     c, out_valid, out_data, err_sel, err_timeout, req_ready);
         end
      end
      release_out();
   endtask

   task automatic test_back_to_back();
      int lat;
      logic [W-1:0] d;
      logic es, et;
      run_txn(9, 32'h00000AAA, 0, lat, d, es, et);
      @(negedge clk);
      out_ready         = 1'b1;
      req_valid         = 1'b1;
      sel               = 4'd1;
      in_data[1*W +: W] = 32'h0B0B0B0B;
      src_valid[1]      = 1'b1;
      #1;
      checks++;
      if (req_ready !== 1'b1) begin
         failures++;
         $display("FAIL b2b_ready got=%b exp=1", req_ready);
      end
      @(posedge clk);
      #1;
      checks++;
      if ({out_valid, err_sel, err_timeout} !== 3'b000) begin
         failures++;
         $display("FAIL b2b_gap got v=%b es=%b et=%b exp v=0 es=0 et=0", out_valid, err_sel, err_timeout);
      end
      @(negedge clk);
      out_ready = 1'b0;
      req_valid = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if ({out_valid, out_data, err_sel} !== {1'b1, 32'h0B0B0B0B, 1'b0}) begin
         failures++;
         $display("FAIL b2b_second got v=%b d=%h es=%b exp v=1 d=0b0b0b0b es=0", out_valid, out_data, err_sel);
      end
      release_out();
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      req_valid = 1'b1;
      sel       = 4'd6;
      src_valid = '0;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({out_valid, req_ready} !== 2'b00) begin
         failures++;
         $display("FAIL mid_wait got v=%b rdy=%b exp v=0 rdy=0", out_valid, req_ready);
      end
      @(negedge clk);
      rst       = 1'b1;
      src_valid = '1;
      @(posedge clk);
      #1;
      checks++;
      if ({out_valid, err_sel, err_timeout, out_data, req_ready} !== {1'b0, 1'b0, 1'b0, 32'h0, 1'b1}) begin
         failures++;
         $display("FAIL mid_reset got v=%b es=%b et=%b d=%h rdy=%b exp v=0 es=0 et=0 d=0 rdy=1",
                  out_valid, err_sel, err_timeout, out_data, req_ready);
      end
      @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk);
         #1;
         checks++;
         if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL mid_abort_%0d got out_valid=%b exp 0", c, out_valid);
         end
      end
   endtask

   task automatic test_random();
      int s, low, lat, elat, hold;
      logic [W-1:0] v, d, ed;
      logic es, et, ees, eet;
      for (int t = 0; t < 40; t++) begin
         s    = $urandom_range(0, 15);
         low  = $urandom_range(0, 20);
         v    = $urandom;
         hold = $urandom_range(0, 2);
         model_txn(s, v, low, elat, ed, ees, eet);
         run_txn(s, v, low, lat, d, es, et);
         checks++;
         if ({lat, d, es, et} !== {elat, ed, ees, eet}) begin
            failures++;
            $display("FAIL random_%0d sel=%0d low=%0d got lat=%0d d=%h es=%b et=%b exp lat=%0d d=%h es=%b et=%b",
                     t, s, low, lat, d, es, et, elat, ed, ees, eet);
         end
         repeat (hold) @(posedge clk);
         release_out();
         checks++;
         if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL random_release_%0d got out_valid=%b exp 0", t, out_valid);
         end
      end
   endtask

   // ---------------------------------------------------------------- main
   initial begin
      test_reset();
      test_basic();
      test_bad_sel();
      test_timeout();
      test_hold_stable();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule : tb_result_sel_reg
